// File: rtl/pc_sequencer.sv
// Program-counter / control-flow sequencer with start/halt FSM, call-depth tracking and sticky stack error.
// Optional retired-instruction counter enabled by defining PC_SEQ_RETIRE_COUNT_EN.
module pc_sequencer #(
    parameter logic [15:0] RESET_VECTOR = 16'h0000,
    parameter logic [15:0] HALT_WORD    = 16'h3FFF,
    parameter int          STACK_DEPTH  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        enable,
    input  logic [15:0] instr,
    input  logic [15:0] jump_target,
    input  logic        cond,
    input  logic [15:0] stack_top,
    output logic [15:0] count_out,
    output logic        running,
    output logic        halted,
    output logic [4:0]  call_depth,
    output logic        stack_err
`ifdef PC_SEQ_RETIRE_COUNT_EN
    ,
    output logic [31:0] retired_count
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_e;

    localparam logic [4:0] MAX_DEPTH = 5'(STACK_DEPTH);

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [4:0]  depth_q, depth_d;
    logic        err_q, err_d;
`ifdef PC_SEQ_RETIRE_COUNT_EN
    logic [31:0] retire_q, retire_d;
`endif

    // The condition bit is consumed by the return stack, not by PC selection.
    logic cond_unused;
    assign cond_unused = cond;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            pc_q     <= RESET_VECTOR;
            depth_q  <= '0;
            err_q    <= 1'b0;
`ifdef PC_SEQ_RETIRE_COUNT_EN
            retire_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            depth_q  <= depth_d;
            err_q    <= err_d;
`ifdef PC_SEQ_RETIRE_COUNT_EN
            retire_q <= retire_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        depth_d  = depth_q;
        err_d    = err_q;
`ifdef PC_SEQ_RETIRE_COUNT_EN
        retire_d = retire_q;
`endif
        case (state_q)
            IDLE, HALTED: begin
                // Start wins over enable: no decode on the launching edge.
                if (start) begin
                    state_d  = RUN;
                    pc_d     = RESET_VECTOR;
                    depth_d  = '0;
`ifdef PC_SEQ_RETIRE_COUNT_EN
                    retire_d = '0;
`endif
                end
            end
            RUN: begin
                if (enable) begin
                    if (instr == HALT_WORD) begin
                        state_d = HALTED;
                    end else begin
`ifdef PC_SEQ_RETIRE_COUNT_EN
                        retire_d = retire_q + 32'd1;
`endif
                        case (instr[15:14])
                            2'b01: begin
                                pc_d = jump_target;
                                if (depth_q == MAX_DEPTH) err_d = 1'b1;
                                else depth_d = depth_q + 5'd1;
                            end
                            2'b11: begin
                                pc_d = stack_top;
                                if (depth_q == 5'd0) err_d = 1'b1;
                                else depth_d = depth_q - 5'd1;
                            end
                            default: pc_d = pc_q + 16'd1;
                        endcase
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        count_out     = pc_q;
        running       = (state_q == RUN);
        halted        = (state_q == HALTED);
        call_depth    = depth_q;
        stack_err     = err_q;
`ifdef PC_SEQ_RETIRE_COUNT_EN
        retired_count = retire_q;
`endif
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter and control-flow sequencer for one core slice. It drives the instruction-RAM address `count_out` and consumes the fetched instruction word, the jump target/condition word and the call-stack top.
- It is the address-producing end of the core's push/pop return-address interface: on CALL the core's stack pushes `count_out + cond`, and on RETURN the sequencer loads `stack_top`.
- It adds a start/halt state machine, a call-depth tracker that mirrors the stack, and error flags.

Parameters:
- RESET_VECTOR, 16'h0000, PC value loaded on reset and on start.
- HALT_WORD, 16'h3FFF, instruction word that stops sequencing (opcode 00, operand all ones).
- STACK_DEPTH, 16, capacity of the core's return stack; used by the depth tracker.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; leaves IDLE/HALTED and begins fetching at RESET_VECTOR.
- enable  input  1  advance permission; 0 holds the PC and all state (stall).
- instr  input  16  instruction word at `count_out` (combinational RAM read); [15:14] = opcode.
- jump_target  input  16  call/jump destination address.
- cond  input  1  condition bit; informational only (the core's stack uses it), not used for PC selection.
- stack_top  input  16  current top of the return stack.
- count_out  output  16  registered PC = instruction fetch address.
- running  output  1  high in RUN state.
- halted  output  1  high in HALTED state.
- call_depth  output  5  current number of outstanding calls, 0..STACK_DEPTH.
- stack_err  output  1  sticky; set on overflow or underflow.

Behaviour:
- Reset (async, active-high): state=IDLE, `count_out`=RESET_VECTOR, `call_depth`=0, `stack_err`=0, `running`=0, `halted`=0.
- States: IDLE, RUN, HALTED.
  - IDLE: `start`=1 -> RUN; `count_out`=RESET_VECTOR.
  - RUN: a rising edge with `enable`=1 applies the decode below. With `enable`=0, nothing changes.
  - RUN: `instr`==HALT_WORD -> HALTED; PC holds at the halt address.
  - HALTED: PC frozen. `start`=1 -> RUN; PC=RESET_VECTOR, `call_depth`=0; `stack_err` is kept.
- Decode in RUN, `enable`=1, opcode = `instr[15:14]`:
  - 00 (ALU op, non-halt): PC <= PC+1.
  - 10 (store): PC <= PC+1.
  - 01 (CALL): PC <= `jump_target`; `call_depth`+1.
  - 11 (RETURN): PC <= `stack_top`; `call_depth`-1.
- PC+1 is 16-bit modulo: 16'hFFFF -> 16'h0000, with no flag.
- CALL when `call_depth`==STACK_DEPTH: PC still loads `jump_target`; depth saturates; `stack_err` <= 1.
- RETURN when `call_depth`==0: PC still loads `stack_top`; depth stays 0; `stack_err` <= 1.
- `start` while in RUN is ignored.
- `start` and `enable` in the same cycle from IDLE: start takes priority; no decode happens that cycle.
- Reset asserted mid-RUN: all registers return immediately to their reset values, independent of `clk`.
- Latency: the new PC is visible on `count_out` one clock after the decoding edge. `running`/`halted` update on the same edge as the state.
- All outputs are registered. There is no combinational path from `instr` to any output.

Optional Feature:
- Macro: PC_SEQ_RETIRE_COUNT_EN.
- When defined:
  - Adds output `retired_count [31:0]`, reset to 0.
  - Increments by 1 on every RUN edge with `enable`=1 whose `instr` is not HALT_WORD.
  - Wraps modulo 2^32; cleared on start.
- When undefined:
  - The port and its counter are absent.
  - All other behaviour is identical.

Test Plan:
- Reset then `start`; feed `instr`=16'h0000 for 5 enabled cycles -> `count_out` steps 0,1,2,3,4,5; `running`=1.
- At PC=3, `instr`=16'h4000, `jump_target`=16'h0020 -> next `count_out`=16'h0020, `call_depth`=1. Then `instr`=16'hC000, `stack_top`=16'h0004 -> `count_out`=16'h0004, `call_depth`=0.
- `instr`=16'h3FFF at PC=7 -> `halted`=1, `running`=0, PC stays 7 through 10 further clocks. Then `start` -> PC=0, `running`=1.
- RETURN at depth 0 -> `stack_err`=1 and sticky, `call_depth`=0. Then 17 consecutive CALLs -> depth saturates at 16, `stack_err` stays 1.
- Force PC to 16'hFFFF via a CALL with `jump_target`=16'hFFFF; then `instr`=16'h0000 -> PC=16'h0000. Hold `enable`=0 for 3 cycles -> PC unchanged.
- Assert `reset` asynchronously mid-RUN between clock edges -> `count_out`=RESET_VECTOR and state=IDLE before the next edge. With PC_SEQ_RETIRE_COUNT_EN defined, 5 enabled non-halt cycles -> `retired_count`=5.
